operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 194 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: latches one issued instruction, reads its source operands
// from a banked register file (one read + one write per bank per cycle) and presents them to dispatch.
module operand_fetch #(
  parameter int PER_ISSUE_WARPS = 4,
  parameter int NUM_THREADS     = 4,
  parameter int XLEN            = 32,
  parameter int NUM_REGS        = 64,
  parameter int NUM_BANKS       = 4,
  parameter int PAYLOAD_W       = 64,
  localparam int WIS_W = (PER_ISSUE_WARPS > 1) ? $clog2(PER_ISSUE_WARPS) : 1,
  localparam int REG_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int DW    = NUM_THREADS * XLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  // Handshakes on both sides: a transfer happens in a cycle where valid && ready;
  // valid never depends combinationally on ready, and in_ready may depend on out_ready.
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIS_W-1:0]       in_wis,
  input  logic [NUM_THREADS-1:0] in_tmask,
  input  logic [REG_W-1:0]       in_rd,
  input  logic [REG_W-1:0]       in_rs1,
  input  logic [REG_W-1:0]       in_rs2,
  input  logic [REG_W-1:0]       in_rs3,
  input  logic [2:0]             in_used_rs,
  input  logic                   in_wb,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  input  logic                   wb_valid,
  input  logic [WIS_W-1:0]       wb_wis,
  input  logic [REG_W-1:0]       wb_rd,
  input  logic [NUM_THREADS-1:0] wb_tmask,
  input  logic [DW-1:0]          wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIS_W-1:0]       out_wis,
  output logic [NUM_THREADS-1:0] out_tmask,
  output logic [REG_W-1:0]       out_rd,
  output logic                   out_wb,
  output logic [PAYLOAD_W-1:0]   out_payload,
  output logic [DW-1:0]          out_rs1_data,
  output logic [DW-1:0]          out_rs2_data,
  output logic [DW-1:0]          out_rs3_data,
  output logic [31:0]            perf_conflicts,
  output logic [1:0]             dbg_state
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int IDX_W  = (NUM_REGS / NUM_BANKS > 1) ? $clog2(NUM_REGS / NUM_BANKS) : 1;
  localparam int ADDR_W = WIS_W + IDX_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, OUT = 2'd2} state_t;

  function automatic logic [BANK_W-1:0] bank_of(input logic [REG_W-1:0] r);
    int unsigned ri;
    ri = 32'(r);
    return BANK_W'(ri % NUM_BANKS);
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [REG_W-1:0] r);
    int unsigned ri;
    ri = 32'(r);
    return IDX_W'(ri / NUM_BANKS);
  endfunction

  state_t                 state, state_nxt;
  logic [2:0]             pending, pending_nxt, acc_pending;
  logic                   accept, fire;
  logic [WIS_W-1:0]       wis_q;
  logic [NUM_THREADS-1:0] tmask_q;
  logic [REG_W-1:0]       rd_q;
  logic                   wb_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic [REG_W-1:0]       rs_q    [3];
  logic [DW-1:0]          opnd_q  [3];
  logic [NUM_BANKS-1:0]   rd_en, issued_q;
  logic [1:0]             rd_slot [NUM_BANKS];
  logic [1:0]             slot_q  [NUM_BANKS];
  logic [ADDR_W-1:0]      rd_addr [NUM_BANKS];
  logic [DW-1:0]          rd_data [NUM_BANKS];
  logic [31:0]            perf_q;

  assign fire        = (state == OUT) && out_ready;
  assign in_ready    = (state == IDLE) || fire;
  assign accept      = in_valid && in_ready;
  // Register 0 reads as zero, so it never needs a bank read.
  assign acc_pending = in_used_rs & {in_rs3 != '0, in_rs2 != '0, in_rs1 != '0};

  always_comb begin
    pending_nxt = pending;
    rd_en       = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_slot[b] = '0;
      rd_addr[b] = '0;
    end
    if (state == FETCH) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        // Walk from rs3 down so the lowest-numbered pending source wins the bank.
        for (int k = 2; k >= 0; k--) begin
          if (pending[k] && (bank_of(rs_q[k]) == BANK_W'(b))) begin
            rd_en[b]   = 1'b1;
            rd_slot[b] = 2'(k);
            rd_addr[b] = {wis_q, idx_of(rs_q[k])};
          end
        end
        if (rd_en[b]) pending_nxt[rd_slot[b]] = 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (acc_pending == '0) ? OUT : FETCH;
      FETCH:   if (pending == '0) state_nxt = OUT;
      OUT: begin
        if (fire) begin
          if (accept) state_nxt = (acc_pending == '0) ? OUT : FETCH;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      issued_q <= '0;
      perf_q   <= '0;
    end else begin
      state    <= state_nxt;
      issued_q <= rd_en;
      pending  <= accept ? acc_pending : pending_nxt;
      if ((state == FETCH) && (pending_nxt != '0)) perf_q <= perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= rd_slot;
    if (accept) begin
      wis_q     <= in_wis;
      tmask_q   <= in_tmask;
      rd_q      <= in_rd;
      wb_q      <= in_wb;
      payload_q <= in_payload;
      rs_q[0]   <= in_rs1;
      rs_q[1]   <= in_rs2;
      rs_q[2]   <= in_rs3;
      for (int k = 0; k < 3; k++) if (!acc_pending[k]) opnd_q[k] <= '0;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (issued_q[b]) opnd_q[slot_q[b]] <= rd_data[b];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     q;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    assign wr_en   = wb_valid && (wb_rd != '0) && (bank_of(wb_rd) == BANK_W'(b));
    assign wr_addr = {wb_wis, idx_of(wb_rd)};

    // Write-first per lane: a same-entry read sees the new lanes being written.
    always_ff @(posedge clk) begin
      for (int l = 0; l < NUM_THREADS; l++) begin
        if (wr_en && wb_tmask[l]) mem[wr_addr][l*XLEN +: XLEN] <= wb_data[l*XLEN +: XLEN];
        if (rd_en[b]) begin
          if (wr_en && wb_tmask[l] && (wr_addr == rd_addr[b])) q[l*XLEN +: XLEN] <= wb_data[l*XLEN +: XLEN];
          else q[l*XLEN +: XLEN] <= mem[rd_addr[b]][l*XLEN +: XLEN];
        end
      end
    end

    assign rd_data[b] = q;
  end

  assign out_valid      = (state == OUT);
  assign out_wis        = wis_q;
  assign out_tmask      = tmask_q;
  assign out_rd         = rd_q;
  assign out_wb         = wb_q;
  assign out_payload    = payload_q;
  assign out_rs1_data   = opnd_q[0];
  assign out_rs2_data   = opnd_q[1];
  assign out_rs3_data   = opnd_q[2];
  assign perf_conflicts = perf_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic, all checked each cycle
// against a register-file/latency model computed from bank occupancy counts.
module tb_operand_fetch;
  localparam int NW = 4, NT = 4, XL = 32, NR = 64, NB = 4, PW = 64;
  localparam int DW = NT * XL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready;
  logic [1:0]    in_wis;
  logic [NT-1:0] in_tmask;
  logic [5:0]    in_rd, in_rs1, in_rs2, in_rs3;
  logic [2:0]    in_used_rs;
  logic          in_wb;
  logic [PW-1:0] in_payload;
  logic          wb_valid;
  logic [1:0]    wb_wis;
  logic [5:0]    wb_rd;
  logic [NT-1:0] wb_tmask;
  logic [DW-1:0] wb_data;
  logic          out_valid, out_ready;
  logic [1:0]    out_wis;
  logic [NT-1:0] out_tmask;
  logic [5:0]    out_rd;
  logic          out_wb;
  logic [PW-1:0] out_payload;
  logic [DW-1:0] out_rs1_data, out_rs2_data, out_rs3_data;
  logic [31:0]   perf_conflicts;
  logic [1:0]    dbg_state;

  operand_fetch #(
    .PER_ISSUE_WARPS(NW), .NUM_THREADS(NT), .XLEN(XL),
    .NUM_REGS(NR), .NUM_BANKS(NB), .PAYLOAD_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wis(in_wis), .in_tmask(in_tmask),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .in_used_rs(in_used_rs), .in_wb(in_wb), .in_payload(in_payload),
    .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_rd(wb_rd), .wb_tmask(wb_tmask), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_wis(out_wis), .out_tmask(out_tmask),
    .out_rd(out_rd), .out_wb(out_wb), .out_payload(out_payload),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data),
    .perf_conflicts(perf_conflicts), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: register contents plus one in-flight instruction whose
  // per-operand read cycle is its rank among pending operands sharing a bank.
  logic [DW-1:0] ref_rf [NW][NR];
  bit            armed = 0;
  int            cyc = 0;
  bit            busy = 0;
  int            m_acc, m_rdy, m_n;
  int            m_issue [3];
  bit            m_pend [3];
  logic [5:0]    m_rs [3];
  logic [DW-1:0] m_opnd [3];
  logic [1:0]    m_wis;
  logic [NT-1:0] m_tmask;
  logic [5:0]    m_rd;
  logic          m_wb;
  logic [PW-1:0] m_payload;
  logic [31:0]   m_perf = '0;
  logic [3*DW-1:0] exp_q[$];
  bit            last_acc = 0;

  int            s_cyc, acc_cyc;
  logic          s_out_valid, s_in_ready;
  logic [31:0]   s_perf;
  logic [DW-1:0] s_rs1, s_rs2, s_rs3;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, s_cyc);
    end
  endtask

  task automatic compare();
    bit eov, eir;
    logic [DW-1:0] e1, e2, e3;
    eov = busy && (s_cyc >= m_rdy);
    eir = !busy || (eov && out_ready);
    chk("in_ready", DW'(s_in_ready), DW'(eir));
    chk("out_valid", DW'(s_out_valid), DW'(eov));
    chk("perf_conflicts", DW'(s_perf), DW'(m_perf));
    if (eov) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL exp_q_empty: got out_valid expected a queued operand set (cycle %0d)", s_cyc);
      end else begin
        {e3, e2, e1} = exp_q[0];
        chk("rs1_data", s_rs1, e1);
        chk("rs2_data", s_rs2, e2);
        chk("rs3_data", s_rs3, e3);
        chk("out_wis", DW'(out_wis), DW'(m_wis));
        chk("out_tmask", DW'(out_tmask), DW'(m_tmask));
        chk("out_rd", DW'(out_rd), DW'(m_rd));
        chk("out_wb", DW'(out_wb), DW'(m_wb));
        chk("out_payload", DW'(out_payload), DW'(m_payload));
      end
    end
  endtask

  task automatic model_accept(input int c);
    int cnt [NB];
    logic [2:0] used;
    m_rs[0] = in_rs1; m_rs[1] = in_rs2; m_rs[2] = in_rs3;
    m_wis = in_wis; m_tmask = in_tmask; m_rd = in_rd; m_wb = in_wb; m_payload = in_payload;
    used = in_used_rs;
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    m_n = 0;
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = used[k] && (m_rs[k] != 0);
      m_opnd[k] = '0;
      if (m_pend[k]) begin
        m_issue[k] = c + 1 + cnt[m_rs[k] % NB];
        cnt[m_rs[k] % NB]++;
        if (cnt[m_rs[k] % NB] > m_n) m_n = cnt[m_rs[k] % NB];
      end
    end
    m_acc = c;
    m_rdy = (m_n == 0) ? c + 1 : c + m_n + 2;
    busy = 1;
    if (m_n == 0) exp_q.push_back({m_opnd[2], m_opnd[1], m_opnd[0]});
  endtask

  task automatic model_update();
    int c;
    bit mir, fire, acc;
    c = cyc;
    if (wb_valid && wb_rd != 0)
      for (int l = 0; l < NT; l++)
        if (wb_tmask[l]) ref_rf[wb_wis][wb_rd][l*XL +: XL] = wb_data[l*XL +: XL];
    last_acc = 0;
    if (reset) begin
      busy = 0; m_perf = '0; exp_q.delete(); armed = 1;
    end else begin
      mir  = !busy || ((c >= m_rdy) && out_ready);
      fire = busy && (c >= m_rdy) && out_ready;
      acc  = in_valid && mir;
      if (busy) begin
        for (int k = 0; k < 3; k++)
          if (m_pend[k] && m_issue[k] == c) m_opnd[k] = ref_rf[m_wis][m_rs[k]];
        if (c >= m_acc + 1 && c <= m_acc + m_n - 1) m_perf = m_perf + 32'd1;
        if (c + 1 == m_rdy) exp_q.push_back({m_opnd[2], m_opnd[1], m_opnd[0]});
      end
      if (fire) begin
        busy = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      last_acc = acc;
      if (acc) model_accept(c);
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    s_cyc = cyc; s_out_valid = out_valid; s_in_ready = in_ready; s_perf = perf_conflicts;
    s_rs1 = out_rs1_data; s_rs2 = out_rs2_data; s_rs3 = out_rs3_data;
    if (armed) compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wb_write(input int wis, input int rd, input logic [NT-1:0] tm, input logic [DW-1:0] d);
    wb_valid = 1; wb_wis = 2'(wis); wb_rd = 6'(rd); wb_tmask = tm; wb_data = d;
    step();
    wb_valid = 0;
  endtask

  task automatic issue(input int wis, input int rs1, input int rs2, input int rs3, input logic [2:0] used);
    int n = 0;
    in_valid = 1; in_wis = 2'(wis); in_rs1 = 6'(rs1); in_rs2 = 6'(rs2); in_rs3 = 6'(rs3);
    in_used_rs = used; in_tmask = 4'(($urandom_range(1, 15))); in_rd = 6'($urandom_range(0, 63));
    in_wb = 1'($urandom_range(0, 1)); in_payload = {$urandom, $urandom};
    do begin step(); n++; end while (!last_acc && n < 50);
    in_valid = 0;
    acc_cyc = s_cyc;
    if (!last_acc) begin
      checks++; failures++;
      $display("FAIL issue_timeout: got no accept in %0d cycles expected accept", n);
    end
  endtask

  task automatic wait_out(output int lat);
    int n = 0;
    lat = -1;
    do begin step(); n++; end while (!s_out_valid && n < 30);
    if (s_out_valid) lat = s_cyc - acc_cyc;
    else begin
      checks++; failures++;
      $display("FAIL out_timeout: got no out_valid in %0d cycles expected out_valid", n);
    end
  endtask

  function automatic logic [5:0] rand_reg();
    return ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 11)) : 6'($urandom_range(0, 63));
  endfunction

  initial begin
    int lat;
    logic [31:0] p0;
    reset = 1; in_valid = 0; out_ready = 1; wb_valid = 0;
    in_wis = 0; in_tmask = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_rs3 = 0;
    in_used_rs = 0; in_wb = 0; in_payload = 0;
    wb_wis = 0; wb_rd = 0; wb_tmask = 0; wb_data = 0;
    #1;
    // Fill the register file while reset is held.
    for (int w = 0; w < NW; w++)
      for (int r = 1; r < NR; r++)
        wb_write(w, r, 4'hf, {$urandom, $urandom, $urandom, $urandom});
    reset = 0;
    step();
    chk("rst_in_ready", DW'(s_in_ready), DW'(1));
    chk("rst_out_valid", DW'(s_out_valid), DW'(0));
    chk("rst_perf", DW'(s_perf), DW'(0));

    // Three operands in three different banks.
    wb_write(2, 5, 4'hf, {4{32'h05050505}});
    wb_write(2, 6, 4'hf, {4{32'h06060606}});
    wb_write(2, 7, 4'hf, {4{32'h07070707}});
    p0 = s_perf;
    issue(2, 5, 6, 7, 3'b111);
    wait_out(lat);
    chk("nc_latency", DW'(lat), DW'(3));
    chk("nc_rs1", s_rs1, {4{32'h05050505}});
    chk("nc_rs2", s_rs2, {4{32'h06060606}});
    chk("nc_rs3", s_rs3, {4{32'h07070707}});
    chk("nc_perf_delta", DW'(s_perf - p0), DW'(0));

    // All three in bank 1.
    wb_write(2, 1, 4'hf, {4{32'h01010101}});
    wb_write(2, 9, 4'hf, {4{32'h09090909}});
    p0 = s_perf;
    issue(2, 1, 5, 9, 3'b111);
    wait_out(lat);
    chk("cf_latency", DW'(lat), DW'(5));
    chk("cf_perf_delta", DW'(s_perf - p0), DW'(2));
    chk("cf_rs1", s_rs1, {4{32'h01010101}});
    chk("cf_rs2", s_rs2, {4{32'h05050505}});
    chk("cf_rs3", s_rs3, {4{32'h09090909}});

    // r0 source and r0 writeback.
    issue(0, 0, 0, 0, 3'b001);
    wait_out(lat);
    chk("r0_latency", DW'(lat), DW'(1));
    chk("r0_rs1", s_rs1, '0);
    wb_write(0, 0, 4'hf, {DW{1'b1}});
    issue(0, 0, 0, 0, 3'b001);
    wait_out(lat);
    chk("r0_after_wb", s_rs1, '0);

    // Masked writeback in the read-issue cycle.
    wb_write(1, 8, 4'hf, {4{32'h55555555}});
    issue(1, 8, 0, 0, 3'b001);
    wb_valid = 1; wb_wis = 2'd1; wb_rd = 6'd8; wb_tmask = 4'b0101; wb_data = {4{32'hAAAAAAAA}};
    step();
    wb_valid = 0;
    wait_out(lat);
    chk("wf_latency", DW'(lat), DW'(3));
    chk("wf_rs1", s_rs1, 128'h55555555_AAAAAAAA_55555555_AAAAAAAA);

    // Backpressure, then fire and accept in one cycle.
    wb_write(3, 10, 4'hf, {4{32'h0A0A0A0A}});
    wb_write(3, 11, 4'hf, {4{32'h0B0B0B0B}});
    out_ready = 0;
    issue(3, 10, 11, 0, 3'b011);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_in_ready", DW'(s_in_ready), DW'(0));
      chk("bp_out_valid", DW'(s_out_valid), DW'(1));
      chk("bp_rs1", s_rs1, {4{32'h0A0A0A0A}});
      chk("bp_rs2", s_rs2, {4{32'h0B0B0B0B}});
    end
    in_valid = 1; in_wis = 2'd2; in_rs1 = 6'd5; in_rs2 = 0; in_rs3 = 0; in_used_rs = 3'b001;
    out_ready = 1;
    step();
    in_valid = 0;
    acc_cyc = s_cyc;
    chk("bb_in_ready", DW'(s_in_ready), DW'(1));
    chk("bb_out_valid", DW'(s_out_valid), DW'(1));
    wait_out(lat);
    chk("bb_latency", DW'(lat), DW'(3));
    chk("bb_rs1", s_rs1, {4{32'h05050505}});

    // Reset while fetching.
    issue(2, 1, 5, 9, 3'b111);
    step();
    reset = 1;
    step();
    reset = 0;
    step();
    chk("mr_out_valid", DW'(s_out_valid), DW'(0));
    chk("mr_in_ready", DW'(s_in_ready), DW'(1));
    chk("mr_perf", DW'(s_perf), DW'(0));
    issue(2, 5, 9, 0, 3'b011);
    wait_out(lat);
    chk("mr_rs1", s_rs1, {4{32'h05050505}});
    chk("mr_rs2", s_rs2, {4{32'h09090909}});

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_wis     = 2'($urandom_range(0, 3));
      in_rs1     = rand_reg(); in_rs2 = rand_reg(); in_rs3 = rand_reg();
      in_used_rs = 3'($urandom_range(0, 7));
      in_tmask   = 4'($urandom_range(0, 15));
      in_rd      = 6'($urandom_range(0, 63));
      in_wb      = 1'($urandom_range(0, 1));
      in_payload = {$urandom, $urandom};
      out_ready  = ($urandom_range(0, 3) != 0);
      wb_valid   = ($urandom_range(0, 1) != 0);
      wb_wis     = 2'($urandom_range(0, 3));
      wb_rd      = rand_reg();
      wb_tmask   = 4'($urandom_range(0, 15));
      wb_data    = {$urandom, $urandom, $urandom, $urandom};
      reset      = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 0; in_valid = 0; wb_valid = 0; out_ready = 1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
